// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RDWAIT = 1'b1
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester (core, debug) and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [BE_W-1:0]   c_be;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              c_err;
  logic              c_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [BE_W-1:0]   m_be;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_be, c_wdata,
    input  d_req, d_we, d_addr, d_be, d_wdata,
    input  m_rdata,
    output c_gnt, c_rvalid, c_rdata, c_err, c_stall,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_en, m_we, m_addr, m_be, m_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_be, c_wdata,
    output d_req, d_we, d_addr, d_be, d_wdata,
    output m_rdata,
    input  c_gnt, c_rvalid, c_rdata, c_err, c_stall,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_en, m_we, m_addr, m_be, m_wdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_weighted_pick.sv
// Two-way weighted round-robin chooser: core may take up to CORE_BURST
// consecutive grants while debug waits, then debug gets one.
module rr_weighted_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int CORE_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_core,
  input  logic req_dbg,
  output logic gnt_core,
  output logic gnt_dbg
);

  localparam int CW = cnt_w(CORE_BURST);

  logic          last_owner;
  logic [CW-1:0] burst_cnt;
  logic          core_wins;

  assign core_wins = req_core &
                     (~req_dbg | (last_owner == PORT_DBG) | (burst_cnt < CW'(CORE_BURST)));
  assign gnt_core  = en & core_wins;
  assign gnt_dbg   = en & req_dbg & ~core_wins;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= PORT_DBG;
      burst_cnt  <= '0;
    end else if (gnt_dbg) begin
      last_owner <= PORT_DBG;
      burst_cnt  <= '0;
    end else if (gnt_core) begin
      last_owner <= PORT_CORE;
      if (!req_dbg)
        burst_cnt <= '0;
      else if (burst_cnt != CW'(CORE_BURST))
        burst_cnt <= burst_cnt + 1'b1;
    end else if (!req_dbg) begin
      burst_cnt <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port DMEM between the core (port 0) and debug/loader (port 1).
// Grant is combinational in IDLE; reads return data in the following RDWAIT cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int CORE_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  state_t            state;
  logic              owner;
  logic              rd_err;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              idle;
  logic              core_rd_busy;
  logic              c_req_eff;
  logic              gnt_c;
  logic              gnt_d;
  logic              gnt_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              range_err;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_word;

  assign idle         = (state == ST_IDLE) & ~rst;
  // The core keeps c_req up while its read is outstanding; that is not a new request.
  assign core_rd_busy = (state == ST_RDWAIT) & (owner == PORT_CORE);
  assign c_req_eff    = bus.c_req & ~core_rd_busy;

  rr_weighted_pick #(.CORE_BURST(CORE_BURST)) u_pick (
    .clk      (clk),
    .rst      (rst),
    .en       (idle),
    .req_core (c_req_eff),
    .req_dbg  (bus.d_req),
    .gnt_core (gnt_c),
    .gnt_dbg  (gnt_d)
  );

  assign gnt_any   = gnt_c | gnt_d;
  assign sel_we    = gnt_d ? bus.d_we    : bus.c_we;
  assign sel_addr  = gnt_d ? bus.d_addr  : bus.c_addr;
  assign sel_be    = gnt_d ? bus.d_be    : bus.c_be;
  assign sel_wdata = gnt_d ? bus.d_wdata : bus.c_wdata;
  assign range_err = sel_addr >= ADDR_W'(MEM_BYTES);

  assign bus.m_en    = gnt_any & ~range_err;
  assign bus.m_we    = gnt_any & ~range_err & sel_we;
  assign bus.m_addr  = gnt_any ? sel_addr  : '0;
  assign bus.m_be    = gnt_any ? sel_be    : '0;
  assign bus.m_wdata = gnt_any ? sel_wdata : '0;

  assign rd_valid = (state == ST_RDWAIT) & ~rst;
  assign rd_word  = rd_err ? '0 : bus.m_rdata;

  assign bus.c_gnt    = gnt_c;
  assign bus.d_gnt    = gnt_d;
  assign bus.c_rvalid = rd_valid & (owner == PORT_CORE);
  assign bus.d_rvalid = rd_valid & (owner == PORT_DBG);
  assign bus.c_rdata  = bus.c_rvalid ? rd_word : c_rdata_q;
  assign bus.d_rdata  = bus.d_rvalid ? rd_word : d_rdata_q;
  assign bus.c_err    = (gnt_c & sel_we & range_err) | (bus.c_rvalid & rd_err);
  assign bus.d_err    = (gnt_d & sel_we & range_err) | (bus.d_rvalid & rd_err);

  assign bus.c_stall = ~rst & ((c_req_eff & ~gnt_c) |
                               (c_req_eff & ~bus.c_we & gnt_c) |
                               (core_rd_busy & ~bus.c_rvalid));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= PORT_CORE;
      rd_err    <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (state == ST_IDLE) begin
      if (gnt_any && !sel_we) begin
        state  <= ST_RDWAIT;
        owner  <= gnt_d ? PORT_DBG : PORT_CORE;
        rd_err <= range_err;
      end
    end else begin
      state <= ST_IDLE;
      if (owner == PORT_CORE)
        c_rdata_q <= rd_word;
      else
        d_rdata_q <= rd_word;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected grants/read returns are queued at
// stimulus time and a negedge monitor pops and compares them as the DUT emits them.
module tb_dmem_arbiter;

  logic clk;
  logic rst;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096), .CORE_BURST(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple 4 KiB memory macro model, read data one cycle after enable.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.m_be[b]) mem[bus.m_addr[11:2]][b*8 +: 8] <= bus.m_wdata[b*8 +: 8];
      end else begin
        bus.m_rdata <= mem[bus.m_addr[11:2]];
      end
    end
  end

  typedef struct {
    logic        port;
    logic        is_rv;
    logic        err;
    logic        m_en;
    logic        m_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push_gnt(input logic port, input logic we, input logic en, input logic err,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    e.port = port; e.is_rv = 1'b0; e.err = err; e.m_en = en; e.m_we = we & en;
    e.addr = addr; e.wdata = wdata; e.be = be; e.rdata = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_rv(input logic port, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.port = port; e.is_rv = 1'b1; e.err = err; e.m_en = 1'b0; e.m_we = 1'b0;
    e.addr = '0; e.wdata = '0; e.be = '0; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitor: at most one grant or read return happens per cycle.
  exp_t mon_e;
  logic mon_ok, mon_port, mon_rv;
  always @(negedge clk) begin
    if (bus.c_gnt || bus.d_gnt || bus.c_rvalid || bus.d_rvalid) begin
      mon_rv   = bus.c_rvalid | bus.d_rvalid;
      mon_port = bus.d_gnt | bus.d_rvalid;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got event port=%0d rv=%0d, required none", mon_port, mon_rv);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ok = (mon_e.port == mon_port) && (mon_e.is_rv == mon_rv);
        if (mon_rv) begin
          mon_ok = mon_ok && ((mon_port ? bus.d_err : bus.c_err) == mon_e.err) &&
                   ((mon_port ? bus.d_rdata : bus.c_rdata) == mon_e.rdata);
        end else begin
          mon_ok = mon_ok && ((mon_port ? bus.d_err : bus.c_err) == mon_e.err) &&
                   (bus.m_en == mon_e.m_en) && (bus.m_we == mon_e.m_we) &&
                   (!mon_e.m_en || bus.m_addr == mon_e.addr) &&
                   (!mon_e.m_we || (bus.m_wdata == mon_e.wdata && bus.m_be == mon_e.be));
        end
        if (!mon_ok) begin
          fails++;
          $display("FAIL sb_event: got port=%0d rv=%0d err=%0d/%0d rdata=%h/%h m_en=%0d m_we=%0d m_addr=%h m_wdata=%h m_be=%h; required port=%0d rv=%0d err=%0d rdata=%h m_en=%0d m_we=%0d m_addr=%h m_wdata=%h m_be=%h",
                   mon_port, mon_rv, bus.c_err, bus.d_err, bus.c_rdata, bus.d_rdata,
                   bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be,
                   mon_e.port, mon_e.is_rv, mon_e.err, mon_e.rdata, mon_e.m_en, mon_e.m_we,
                   mon_e.addr, mon_e.wdata, mon_e.be);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_c(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_be = be;
  endtask

  task automatic drv_d(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_be = be;
  endtask

  initial begin
    rst = 1'b1;
    drv_c(0, 0, 0, 0, 0);
    drv_d(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {23'd0, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.c_err,
                       bus.d_err, bus.m_en, bus.m_we, bus.c_stall}, 32'd0);
    chk("reset_c_rdata", bus.c_rdata, 32'd0);
    chk("reset_d_rdata", bus.d_rdata, 32'd0);
    cyc(); rst = 1'b0;

    // Core write, granted in the request cycle, no stall
    cyc(); push_gnt(0, 1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF);
    drv_c(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk); chk("wr_stall", {31'd0, bus.c_stall}, 32'd0);
    cyc(); drv_c(0, 0, 0, 0, 0);
    @(negedge clk); chk("wr_idle_m_en", {31'd0, bus.m_en}, 32'd0);

    // Core read: one stall cycle, data the next cycle
    cyc(); push_gnt(0, 0, 1, 0, 32'h10, 0, 0); push_rv(0, 0, 32'hDEADBEEF);
    drv_c(1, 0, 32'h10, 0, 0);
    @(negedge clk); chk("rd_stall_c0", {31'd0, bus.c_stall}, 32'd1);
    cyc();
    @(negedge clk); chk("rd_stall_c1", {31'd0, bus.c_stall}, 32'd0);
    cyc(); drv_c(0, 0, 0, 0, 0);
    @(negedge clk); chk("rd_hold", bus.c_rdata, 32'hDEADBEEF);

    // Continuous contention: C,C,C,C,D,C,C,C,C,D
    cyc();
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) push_gnt(1, 1, 1, 0, 32'h40, 32'hD0D00040, 4'hF);
      else            push_gnt(0, 1, 1, 0, 32'h20, 32'hC0C00020, 4'hF);
    end
    drv_c(1, 1, 32'h20, 32'hC0C00020, 4'hF);
    drv_d(1, 1, 32'h40, 32'hD0D00040, 4'hF);
    for (int i = 0; i < 10; i++) begin
      if (i != 0) cyc();
      @(negedge clk);
      chk("burst_stall", {31'd0, bus.c_stall}, (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    cyc(); drv_c(0, 0, 0, 0, 0); drv_d(0, 0, 0, 0, 0);

    // Debug out-of-range read
    cyc(); push_gnt(1, 0, 0, 0, 32'h2000, 0, 0); push_rv(1, 1, 32'd0);
    drv_d(1, 0, 32'h2000, 0, 0);
    @(negedge clk);
    cyc(); drv_d(0, 0, 0, 0, 0);
    @(negedge clk);
    cyc();
    @(negedge clk); chk("err_pulse", {31'd0, bus.d_err}, 32'd0);

    // Core write at MEM_BYTES is rejected without touching memory
    cyc(); push_gnt(0, 1, 0, 1, 32'h1000, 32'h11111111, 4'hF);
    drv_c(1, 1, 32'h1000, 32'h11111111, 4'hF);
    @(negedge clk);
    cyc(); drv_c(0, 0, 0, 0, 0);

    // Last in-range word: full write, partial write, read back
    cyc(); push_gnt(1, 1, 1, 0, 32'hFFC, 32'hA5A5A5A5, 4'hF);
    drv_d(1, 1, 32'hFFC, 32'hA5A5A5A5, 4'hF);
    @(negedge clk);
    cyc(); push_gnt(1, 1, 1, 0, 32'hFFC, 32'h0000BEEF, 4'h3);
    drv_d(1, 1, 32'hFFC, 32'h0000BEEF, 4'h3);
    @(negedge clk);
    cyc(); push_gnt(1, 0, 1, 0, 32'hFFC, 0, 0); push_rv(1, 0, 32'hA5A5BEEF);
    drv_d(1, 0, 32'hFFC, 0, 0);
    @(negedge clk);
    cyc(); drv_d(0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset during an outstanding core read, with a debug request held across it
    cyc(); push_gnt(0, 0, 1, 0, 32'h10, 0, 0);
    drv_c(1, 0, 32'h10, 0, 0);
    @(negedge clk);
    cyc(); rst = 1'b1; drv_c(0, 0, 0, 0, 0);
    drv_d(1, 1, 32'h80, 32'h80808080, 4'hF);
    @(negedge clk);
    chk("rst_no_rvalid", {31'd0, bus.c_rvalid}, 32'd0);
    chk("rst_no_dgnt", {31'd0, bus.d_gnt}, 32'd0);
    cyc(); rst = 1'b0; push_gnt(1, 1, 1, 0, 32'h80, 32'h80808080, 4'hF);
    @(negedge clk); chk("rst_rdata_clr", bus.c_rdata, 32'd0);
    cyc(); drv_d(0, 0, 0, 0, 0);

    // Debug read outstanding while a core write arrives
    cyc(); push_gnt(1, 0, 1, 0, 32'h40, 0, 0); push_rv(1, 0, 32'hD0D00040);
    drv_d(1, 0, 32'h40, 0, 0);
    @(negedge clk);
    cyc(); drv_d(0, 0, 0, 0, 0);
    push_gnt(0, 1, 1, 0, 32'h30, 32'h12345678, 4'hF);
    drv_c(1, 1, 32'h30, 32'h12345678, 4'hF);
    @(negedge clk);
    chk("dbg_rd_c_stall", {31'd0, bus.c_stall}, 32'd1);
    chk("dbg_rd_no_cgnt", {31'd0, bus.c_gnt}, 32'd0);
    cyc();
    @(negedge clk);
    chk("after_rv_cgnt", {31'd0, bus.c_gnt}, 32'd1);
    chk("after_rv_stall", {31'd0, bus.c_stall}, 32'd0);
    cyc(); drv_c(0, 0, 0, 0, 0);

    repeat (3) cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
